// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode output, forwards EX/MEM and
// MEM/WB results into the ALU operands, and inserts load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [3:0]        alu_ctrl_i,
    input  logic              alusrc_i,
    input  logic              regwrite_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              memtoreg_i,
    input  logic              exmem_regwrite_i,
    input  logic [ADDR_W-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_regwrite_i,
    input  logic [ADDR_W-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [3:0]        control_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              regwrite_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              memtoreg_o,
    output logic              valid_o,
    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [3:0]        ctrl;
        logic              alusrc;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    id_ex_t           q;
    id_ex_t           cap;
    logic [CNT_W-1:0] cnt_q;
    logic             lu;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;

    // An all-zero bundle is the bubble; a non-valid capture is one too.
    always_comb begin
        cap = '0;
        if (valid_i) begin
            cap.valid    = 1'b1;
            cap.ctrl     = alu_ctrl_i;
            cap.alusrc   = alusrc_i;
            cap.regwrite = regwrite_i;
            cap.memread  = memread_i;
            cap.memwrite = memwrite_i;
            cap.memtoreg = memtoreg_i;
            cap.rs1      = rs1_addr_i;
            cap.rs2      = rs2_addr_i;
            cap.rd       = rd_addr_i;
            cap.d1       = rs1_data_i;
            cap.d2       = rs2_data_i;
            cap.imm      = imm_i;
        end
    end

    always_comb begin
        lu = q.valid & q.memread & (q.rd != '0) & valid_i
           & ((q.rd == rs1_addr_i) | (q.rd == rs2_addr_i))
           & ~stall_i & ~flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            q     <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            q <= '0;
        end else if (!stall_i) begin
            if (lu) begin
                q <= '0;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else begin
                q <= cap;
            end
        end
    end

    function automatic logic [DATA_W-1:0] fwd(
        input logic [ADDR_W-1:0] rs,
        input logic [DATA_W-1:0] rf,
        input logic              ex_we,
        input logic [ADDR_W-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_d,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_d
    );
        if (ex_we && ex_rd != '0 && ex_rd == rs) return ex_d;
        if (wb_we && wb_rd != '0 && wb_rd == rs) return wb_d;
        return rf;
    endfunction

    always_comb begin
        fwd1 = fwd(q.rs1, q.d1,
                   exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                   memwb_regwrite_i, memwb_rd_i, memwb_data_i);
        fwd2 = fwd(q.rs2, q.d2,
                   exmem_regwrite_i, exmem_rd_i, exmem_data_i,
                   memwb_regwrite_i, memwb_rd_i, memwb_data_i);
    end

    assign data1_o          = fwd1;
    assign data2_o          = q.alusrc ? q.imm : fwd2;
    assign store_data_o     = fwd2;
    assign control_o        = q.ctrl;
    assign rd_addr_o        = q.rd;
    assign regwrite_o       = q.regwrite;
    assign memread_o        = q.memread;
    assign memwrite_o       = q.memwrite;
    assign memtoreg_o       = q.memtoreg;
    assign valid_o          = q.valid;
    assign load_use_stall_o = lu;
    assign bubble_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan cases with literal checks,
// then random traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i, stall_i, flush_i, valid_i;
    logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i;
    logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]    alu_ctrl_i;
    logic          alusrc_i, regwrite_i, memread_i, memwrite_i, memtoreg_i;
    logic          exmem_regwrite_i, memwb_regwrite_i;
    logic [AW-1:0] exmem_rd_i, memwb_rd_i;
    logic [DW-1:0] exmem_data_i, memwb_data_i;
    logic [DW-1:0] data1_o, data2_o, store_data_o;
    logic [3:0]    control_o;
    logic [AW-1:0] rd_addr_o;
    logic          regwrite_o, memread_o, memwrite_o, memtoreg_o;
    logic          valid_o, load_use_stall_o;
    logic [CW-1:0] bubble_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i), .alu_ctrl_i(alu_ctrl_i), .alusrc_i(alusrc_i),
        .regwrite_i(regwrite_i), .memread_i(memread_i),
        .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i),
        .exmem_data_i(exmem_data_i), .memwb_regwrite_i(memwb_regwrite_i),
        .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .data1_o(data1_o), .data2_o(data2_o), .control_o(control_o),
        .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
        .regwrite_o(regwrite_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o),
        .valid_o(valid_o), .load_use_stall_o(load_use_stall_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: what the stage holds, as one instruction record.
    bit          m_valid, m_alusrc, m_rw, m_mr, m_mw, m_mtr;
    logic [3:0]  m_ctrl;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    logic [DW-1:0] m_d1, m_d2, m_imm;
    int          m_cnt = 0;

    task automatic m_clear();
        m_valid = 0; m_alusrc = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
        m_ctrl = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_d1 = '0; m_d2 = '0; m_imm = '0;
    endtask

    function automatic bit m_hazard();
        if (stall_i || flush_i || !valid_i) return 0;
        if (!(m_valid && m_mr) || m_rd == 0) return 0;
        return (m_rd == rs1_addr_i) || (m_rd == rs2_addr_i);
    endfunction

    function automatic logic [DW-1:0] m_fwd(input logic [AW-1:0] rs,
                                            input logic [DW-1:0] rf);
        if (rs == 0) return rf;
        if (exmem_regwrite_i && exmem_rd_i == rs) return exmem_data_i;
        if (memwb_regwrite_i && memwb_rd_i == rs) return memwb_data_i;
        return rf;
    endfunction

    initial m_clear();

    always @(posedge clk) begin
        if (!rst_i) begin
            m_clear();
            m_cnt = 0;
        end else if (flush_i) begin
            m_clear();
        end else if (stall_i) begin
            m_cnt = m_cnt;
        end else if (m_hazard()) begin
            m_clear();
            if (m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else if (valid_i) begin
            m_valid = 1; m_ctrl = alu_ctrl_i; m_alusrc = alusrc_i;
            m_rw = regwrite_i; m_mr = memread_i; m_mw = memwrite_i;
            m_mtr = memtoreg_i; m_rs1 = rs1_addr_i; m_rs2 = rs2_addr_i;
            m_rd = rd_addr_i; m_d1 = rs1_data_i; m_d2 = rs2_data_i;
            m_imm = imm_i;
        end else begin
            m_clear();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid", valid_o, m_valid);
            chk("control", control_o, m_ctrl);
            chk("rd", rd_addr_o, m_rd);
            chk("regwrite", regwrite_o, m_rw);
            chk("memread", memread_o, m_mr);
            chk("memwrite", memwrite_o, m_mw);
            chk("memtoreg", memtoreg_o, m_mtr);
            chk("bubble_cnt", bubble_cnt_o, m_cnt);
            chk("load_use", load_use_stall_o, m_hazard());
            if (m_valid) begin
                chk("data1", data1_o, m_fwd(m_rs1, m_d1));
                chk("data2", data2_o,
                    m_alusrc ? m_imm : m_fwd(m_rs2, m_d2));
                chk("store", store_data_o, m_fwd(m_rs2, m_d2));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] ctrl, input logic mr,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd);
        valid_i = 1; alu_ctrl_i = ctrl; memread_i = mr;
        rs1_addr_i = rs1; rs2_addr_i = rs2; rd_addr_i = rd;
        regwrite_i = 1; memtoreg_i = mr; memwrite_i = 0; alusrc_i = 0;
    endtask

    initial begin
        rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 1;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0;
        alu_ctrl_i = 4'b0010; alusrc_i = 0; regwrite_i = 1;
        memread_i = 0; memwrite_i = 0; memtoreg_i = 0;
        exmem_regwrite_i = 0; exmem_rd_i = '0; exmem_data_i = '0;
        memwb_regwrite_i = 0; memwb_rd_i = '0; memwb_data_i = '0;

        tick();
        chk_on = 1;
        tick();
        @(negedge clk);
        chk("rst control", control_o, 4'b0000);
        chk("rst valid", valid_o, 0);
        chk("rst cnt", bubble_cnt_o, 0);
        rst_i = 1;
        tick();
        @(negedge clk);
        chk("release control", control_o, 4'b0010);
        chk("release valid", valid_o, 1);

        instr(4'b0101, 0, 5'd1, 5'd2, 5'd6);
        alusrc_i = 1; rs1_data_i = 32'd5; imm_i = 32'hFFFF_FFFC;
        tick();
        @(negedge clk);
        chk("imm data1", data1_o, 32'd5);
        chk("imm data2", data2_o, 32'hFFFF_FFFC);
        chk("imm control", control_o, 4'b0101);

        instr(4'b0010, 0, 5'd3, 5'd2, 5'd6);
        rs1_data_i = 32'd1;
        exmem_regwrite_i = 1; exmem_rd_i = 5'd3; exmem_data_i = 32'h11;
        memwb_regwrite_i = 1; memwb_rd_i = 5'd3; memwb_data_i = 32'h22;
        tick();
        @(negedge clk);
        chk("fwd exmem", data1_o, 32'h11);
        exmem_regwrite_i = 0;
        #1 chk("fwd memwb", data1_o, 32'h22);
        exmem_regwrite_i = 1; exmem_rd_i = '0; memwb_rd_i = '0;
        #1 chk("fwd x0", data1_o, 32'd1);
        exmem_regwrite_i = 0; memwb_regwrite_i = 0;

        tick();
        instr(4'b0110, 1, 5'd1, 5'd2, 5'd7);
        tick();
        instr(4'b0010, 0, 5'd4, 5'd7, 5'd8);
        @(negedge clk);
        chk("lu stall", load_use_stall_o, 1);
        tick();
        @(negedge clk);
        chk("lu bubble valid", valid_o, 0);
        chk("lu bubble ctrl", control_o, 4'b0000);
        chk("lu bubble cnt", bubble_cnt_o, 1);
        chk("lu released", load_use_stall_o, 0);
        tick();
        @(negedge clk);
        chk("lu dep rd", rd_addr_o, 5'd8);
        chk("lu dep valid", valid_o, 1);

        instr(4'b0110, 1, 5'd1, 5'd2, 5'd0);
        tick();
        instr(4'b0010, 0, 5'd0, 5'd0, 5'd8);
        @(negedge clk);
        chk("lu x0", load_use_stall_o, 0);

        instr(4'b0010, 0, 5'd4, 5'd5, 5'd9);
        tick();
        instr(4'b0001, 0, 5'd1, 5'd2, 5'd3);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("stall ctrl", control_o, 4'b0010);
            chk("stall valid", valid_o, 1);
            chk("stall lu", load_use_stall_o, 0);
        end
        flush_i = 1;
        tick();
        @(negedge clk);
        chk("stall+flush valid", valid_o, 0);
        stall_i = 0; flush_i = 0;

        rst_i = 0;
        tick();
        rst_i = 1;
        instr(4'b0110, 1, 5'd7, 5'd7, 5'd7);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sat lu", load_use_stall_o, 1);
            tick();
            @(negedge clk);
            chk("sat cnt", bubble_cnt_o, (i + 1 > 3) ? 3 : i + 1);
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            rst_i            = ($urandom_range(99) != 0);
            stall_i          = ($urandom_range(9) == 0);
            flush_i          = ($urandom_range(19) == 0);
            valid_i          = ($urandom_range(3) != 0);
            rs1_data_i       = $urandom;
            rs2_data_i       = $urandom;
            imm_i            = $urandom;
            rs1_addr_i       = AW'($urandom_range(7));
            rs2_addr_i       = AW'($urandom_range(7));
            rd_addr_i        = AW'($urandom_range(7));
            alu_ctrl_i       = 4'($urandom_range(8));
            alusrc_i         = 1'($urandom);
            regwrite_i       = 1'($urandom);
            memread_i        = ($urandom_range(2) == 0);
            memwrite_i       = 1'($urandom);
            memtoreg_i       = 1'($urandom);
            exmem_regwrite_i = 1'($urandom);
            exmem_rd_i       = AW'($urandom_range(7));
            exmem_data_i     = $urandom;
            memwb_regwrite_i = 1'($urandom);
            memwb_rd_i       = AW'($urandom_range(7));
            memwb_data_i     = $urandom;
            tick();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage CPU. Captures decoded operands and control from the decode stage.
- Resolves EX-stage data forwarding and drives the ALU operand and control inputs: data1, data2, 4-bit control.
- Detects load-use hazards, inserts bubbles, and honours external stall and flush requests.

Parameters:
- DATA_W, 32, operand and immediate width.
- ADDR_W, 5, register-file address width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous, active-low reset.
- stall_i in 1: hold all stage contents.
- flush_i in 1: replace the stage contents with a bubble (branch redirect).
- valid_i in 1: the decode stage presents a real instruction.
- rs1_data_i in DATA_W: register-file read data 1.
- rs2_data_i in DATA_W: register-file read data 2.
- imm_i in DATA_W: sign-extended immediate.
- rs1_addr_i in ADDR_W: source register 1 address.
- rs2_addr_i in ADDR_W: source register 2 address.
- rd_addr_i in ADDR_W: destination register address.
- alu_ctrl_i in 4: ALU opcode (0000 or, 0001 and, 0010 add, 0011 sub, 0100 mul, 0101 addi, 0110 ld, 0111 sd, 1000 beq).
- alusrc_i, regwrite_i, memread_i, memwrite_i, memtoreg_i in 1 each: decoded control bits.
- exmem_regwrite_i in 1, exmem_rd_i in ADDR_W, exmem_data_i in DATA_W: EX/MEM forwarding source.
- memwb_regwrite_i in 1, memwb_rd_i in ADDR_W, memwb_data_i in DATA_W: MEM/WB forwarding source.
- data1_o out DATA_W: ALU operand 1.
- data2_o out DATA_W: ALU operand 2.
- control_o out 4: ALU control.
- store_data_o out DATA_W: forwarded rs2 value, used for sd.
- rd_addr_o out ADDR_W: registered destination address.
- regwrite_o, memread_o, memwrite_o, memtoreg_o out 1 each: registered control bits.
- valid_o out 1: the stage holds a real instruction.
- load_use_stall_o out 1: request to freeze PC and IF/ID.
- bubble_cnt_o out CNT_W: count of load-use bubbles inserted.

Behaviour:
- Reset (rst_i=0 at a clk_i edge): all registered fields clear to 0. Outputs then read: control_o=0000, valid_o=0, all control bits 0, bubble_cnt_o=0. A reset overrides every other input, including mid-stall.
- Hazard term (combinational): load_use_stall_o = valid_o & memread_o & (rd_addr_o != 0) & valid_i & (rd_addr_o == rs1_addr_i | rd_addr_o == rs2_addr_i). It is forced to 0 while stall_i=1 or flush_i=1.
- Register update priority per rising edge:
  1. reset.
  2. flush_i: load a bubble.
  3. stall_i: hold every field, including the counter.
  4. load_use_stall_o: load a bubble and increment the counter.
  5. otherwise: capture all *_i fields.
- Bubble contents: valid=0, control=0000, regwrite/memread/memwrite/memtoreg=0, rd=0. Data fields are don't-care but are driven to 0.
- Capture with valid_i=0 is also a bubble: control fields are cleared regardless of the input values.
- Forwarding (combinational, after the register). Applied separately to the registered rs1 and rs2:
  - Use exmem_data_i if exmem_regwrite_i & exmem_rd_i != 0 & exmem_rd_i == rsX_q.
  - Otherwise use memwb_data_i under the same conditions with the MEM/WB inputs.
  - Otherwise use the registered rsX data.
  - EX/MEM wins when both sources match.
  - Register x0 is never forwarded.
- Operand outputs:
  - data1_o = fwd_rs1.
  - data2_o = alusrc_q ? imm_q : fwd_rs2.
  - store_data_o = fwd_rs2 always.
- control_o = registered alu_ctrl; 0000 for a bubble.
- Latency: decode fields appear on the outputs 1 cycle after capture. Forwarding paths have 0-cycle latency.
- bubble_cnt_o increments by 1 per inserted load-use bubble and saturates at all-ones (no wrap).

Test Plan:
- Reset then release: rst_i=0 for 2 cycles with valid_i=1, alu_ctrl_i=0010 -> during reset all outputs 0, control_o=0000. The first edge after release captures the instruction: control_o=0010, valid_o=1.
- Capture and immediate: rs1_data_i=5, imm_i=0xFFFFFFFC, alusrc_i=1, alu_ctrl_i=0101, no forwarding -> next cycle data1_o=5, data2_o=0xFFFFFFFC, control_o=0101.
- Forwarding priority: registered rs1=x3 with rs1_data=1; exmem_rd_i=3, exmem_data_i=0x11, memwb_rd_i=3, memwb_data_i=0x22, both regwrite=1 -> data1_o=0x11. Drop exmem_regwrite_i -> data1_o=0x22. Set both rd to 0 -> data1_o=1.
- Load-use: stage holds ld (memread=1, rd=x7, valid=1); incoming rs2_addr_i=7, valid_i=1 ->
  - load_use_stall_o=1 for that cycle.
  - Next cycle: valid_o=0, control_o=0000, bubble_cnt_o=1.
  - The following cycle, with load_use_stall_o now 0, the dependent instruction is captured.
  - Same case with rd=x0 -> no stall.
- Stall vs flush: with the stage holding add (control_o=0010), assert stall_i for 3 cycles -> outputs unchanged and load_use_stall_o=0. Assert stall_i and flush_i together -> bubble next cycle: valid_o=0.
- Counter saturation: CNT_W=2; force 5 consecutive load-use bubbles -> bubble_cnt_o goes 1, 2, 3, 3, 3.
